vga_write_arbiter: RTL and testbench
====================================

# vga_write_arbiter

Owns the single pixel-write port of the VGA adapter and hands it to whichever renderer (menu, reaction, chimp) the current game mode selects. On reset and on every game-mode change, it first sweeps the whole screen to a clear colour, then asserts exactly one renderer enable and grants that renderer's write requests. It sits between the game-mode source and the three renderers on one side, and the VGA adapter's plot interface on the other.

## Interface
- SCREEN_W, 160, horizontal pixels
- SCREEN_H, 120, vertical pixels
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- CLEAR_COLOUR, 0, colour written during the clear sweep
---
- clk  in  1  system clock; one clock domain for the whole block
- resetn  in  1  asynchronous, active-low reset
- iGameMode  in  2  0 menu, 1 reaction, 2 chimp, 3 none
- iReq  in  3  per-renderer write request; bit 0 menu, bit 1 reaction, bit 2 chimp
- iX  in  3×X_W  per-renderer x, packed by the same index
- iY  in  3×Y_W  per-renderer y
- iColour  in  3×COLOUR_W  per-renderer colour
- oGnt  out  3  per-renderer grant (combinational)
- oMenuEnable / oReactionEnable / oChimpEnable  out  1 each  renderer enables (registered)
- oX, oY, oColour, oPlot  out  X_W, Y_W, COLOUR_W, 1  VGA adapter write port (registered)
- oClearing  out  1  clear sweep in progress
- oDropped  out  1  sticky: a granted write had out-of-range coordinates

## Operation
- States: CLEAR, RUN. A latched mode register, qMode, records the mode in force.
- Reset:
  - state=CLEAR, qMode=iGameMode sampled at the first edge after release, counters x=y=0.
  - All outputs 0 except oClearing=1.
- CLEAR:
  - Each cycle, plot (cx, cy, CLEAR_COLOUR).
  - cx increments 0..SCREEN_W-1, then wraps to 0 with cy+1.
  - After pixel (SCREEN_W-1, SCREEN_H-1), go to RUN.
  - oGnt=0 throughout. All enables 0.
- RUN:
  - Enable bit qMode is 1, the others are 0. qMode=3 means all enables are 0 and no grants are given.
  - oGnt[k] = iReq[k] & (k==qMode) & (iGameMode==qMode).
  - A granted request transfers that cycle: iX/iY/iColour[k] are registered onto oX/oY/oColour with oPlot=1.
  - Requests from non-selected renderers are ignored (no grant) and must be held by the renderer.
- Mode change (iGameMode != qMode, evaluated every cycle in both states):
  - qMode←iGameMode, state←CLEAR, cx=cy=0, enables drop at the same edge.
  - A mode change mid-CLEAR restarts the sweep from (0,0).
- Out-of-range write (iX ≥ SCREEN_W or iY ≥ SCREEN_H):
  - The grant is still given, so the renderer does not stall.
  - oPlot stays 0 and oDropped is set.
  - oDropped clears only on reset or on entry to CLEAR.
- Width rules:
  - Comparisons are unsigned.
  - The clear counters saturate logic at the terminal values. They never exceed SCREEN_W-1 / SCREEN_H-1.

## Timing
- Write latency: request granted in cycle n → oPlot=1 with that data in cycle n+1. Throughput is one pixel per cycle.
- oPlot is high for exactly one cycle per accepted pixel. With no grant, oPlot=0 and oX/oY/oColour hold their last values.
- Clear sweep: SCREEN_W×SCREEN_H cycles of oPlot=1 (19200 at defaults).
  - The first clear plot appears 1 cycle after entering CLEAR.
  - oClearing falls and the enable rises on the same edge, 1 cycle after the last clear pixel is issued.
- oGnt is 0 during the cycle in which iGameMode differs from qMode, so no renderer write lands after a mode switch is seen.
- Asynchronous reset mid-sweep or mid-write aborts immediately. No partial plot is issued after resetn falls.

## Structure
- Shared package vga_pkg:
  - game_mode_e {MODE_MENU=0, MODE_REACTION=1, MODE_CHIMP=2, MODE_NONE=3}
  - arb_state_e {ST_CLEAR, ST_RUN}
  - SCREEN_W / SCREEN_H / COLOUR_W defaults
- Sub-module vga_raster_counter: x/y counter with clear, enable, and a done flag on the last pixel; reused later by full-screen renderers.

## Test plan
- Reset release with iGameMode=0 → 19200 consecutive oPlot pulses covering (0,0)…(159,119) with colour 0 → then oMenuEnable=1, oClearing=0.
- RUN mode 1, iReq=3'b111 with reaction pixel (10,20,5) → oGnt=3'b010, next cycle oPlot=1 at (10,20,5); menu/chimp get no grant.
- iGameMode 1→2 while iReq[1] is held → oGnt=0 that cycle, oReactionEnable drops, sweep restarts, and oChimpEnable=1 only after 19200 plots.
- Mode change at clear pixel 5000 → sweep restarts at (0,0) and completes 19200 plots from the restart point.
- Granted write at (160,5) → oGnt=1, no oPlot, oDropped=1 until the next CLEAR.
- iGameMode=3 after its clear → all enables 0 and no grants for any iReq.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and screen geometry for the VGA write arbiter and renderers.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_MENU     = 2'd0,
        MODE_REACTION = 2'd1,
        MODE_CHIMP    = 2'd2,
        MODE_NONE     = 2'd3
    } game_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COLOUR_W     = 3;
    localparam int CLEAR_COLOUR = 0;
    localparam int N_REQ        = 3;

    function automatic logic [N_REQ-1:0] mode_onehot(input game_mode_e m);
        case (m)
            MODE_MENU:     return 3'b001;
            MODE_REACTION: return 3'b010;
            MODE_CHIMP:    return 3'b100;
            default:       return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Raster-order x/y counter; done rises once the last pixel has been stepped past.
module vga_raster_counter #(
    parameter int W  = 160,
    parameter int H  = 120,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done
);

    localparam logic [XW-1:0] XMAX = XW'(W - 1);
    localparam logic [YW-1:0] YMAX = YW'(H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;
    logic          last;

    always_comb begin
        last   = (x_q == XMAX) && (y_q == YMAX);
        x_d    = x_q;
        y_d    = y_q;
        done_d = done_q;
        if (clr) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            // Counters park on the terminal pixel rather than wrapping.
            if (last) begin
                done_d = 1'b1;
            end else if (x_q == XMAX) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign done = done_q;

endmodule

// File: rtl/vga_write_arbiter.sv
// Owns the VGA plot port: clears the screen on each mode change, then
// grants the pixel writes of the renderer selected by the game mode.
module vga_write_arbiter #(
    parameter int SCREEN_W     = 160,
    parameter int SCREEN_H     = 120,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOUR_W     = 3,
    parameter int CLEAR_COLOUR = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            iGameMode,
    input  logic [2:0]            iReq,
    input  logic [3*X_W-1:0]      iX,
    input  logic [3*Y_W-1:0]      iY,
    input  logic [3*COLOUR_W-1:0] iColour,
    output logic [2:0]            oGnt,
    output logic                  oMenuEnable,
    output logic                  oReactionEnable,
    output logic                  oChimpEnable,
    output logic [X_W-1:0]        oX,
    output logic [Y_W-1:0]        oY,
    output logic [COLOUR_W-1:0]   oColour,
    output logic                  oPlot,
    output logic                  oClearing,
    output logic                  oDropped
);

    import vga_pkg::*;

    localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

    arb_state_e            state_q, state_d;
    game_mode_e            mode_q, mode_d, mode_in;
    logic                  init_q, init_d;
    logic [2:0]            en_q, en_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [COLOUR_W-1:0]   col_q, col_d;
    logic                  plot_q, plot_d;
    logic                  drop_q, drop_d;

    logic                  mode_chg;
    logic                  in_range;
    logic [2:0]            gnt;
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [COLOUR_W-1:0]   sel_col;
    logic                  cnt_clr, cnt_step, cnt_done;
    logic [X_W-1:0]        cx;
    logic [Y_W-1:0]        cy;

    vga_raster_counter #(
        .W  (SCREEN_W),
        .H  (SCREEN_H),
        .XW (X_W),
        .YW (Y_W)
    ) u_raster (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (cnt_step),
        .x      (cx),
        .y      (cy),
        .done   (cnt_done)
    );

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_col = '0;
        case (mode_q)
            MODE_MENU: begin
                sel_x   = iX[0 +: X_W];
                sel_y   = iY[0 +: Y_W];
                sel_col = iColour[0 +: COLOUR_W];
            end
            MODE_REACTION: begin
                sel_x   = iX[X_W +: X_W];
                sel_y   = iY[Y_W +: Y_W];
                sel_col = iColour[COLOUR_W +: COLOUR_W];
            end
            MODE_CHIMP: begin
                sel_x   = iX[2*X_W +: X_W];
                sel_y   = iY[2*Y_W +: Y_W];
                sel_col = iColour[2*COLOUR_W +: COLOUR_W];
            end
            default: ;
        endcase
        in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    end

    always_comb begin
        mode_in  = game_mode_e'(iGameMode);
        mode_chg = init_q && (mode_in != mode_q);
        state_d  = state_q;
        // The first edge after reset adopts whatever mode is presented.
        mode_d   = init_q ? mode_q : mode_in;
        init_d   = 1'b1;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        plot_d   = 1'b0;
        drop_d   = drop_q;
        gnt      = '0;
        cnt_clr  = 1'b0;
        cnt_step = 1'b0;

        if (mode_chg) begin
            state_d = ST_CLEAR;
            mode_d  = mode_in;
            cnt_clr = 1'b1;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (!cnt_done) begin
                        plot_d   = 1'b1;
                        x_d      = cx;
                        y_d      = cy;
                        col_d    = COLOUR_W'(CLEAR_COLOUR);
                        cnt_step = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    gnt = iReq & mode_onehot(mode_q);
                    // Out-of-range writes are still granted so the renderer moves on.
                    if (|gnt) begin
                        if (in_range) begin
                            plot_d = 1'b1;
                            x_d    = sel_x;
                            y_d    = sel_y;
                            col_d  = sel_col;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        en_d = (state_d == ST_RUN) ? mode_onehot(mode_d) : 3'b000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_CLEAR;
            mode_q  <= MODE_MENU;
            init_q  <= 1'b0;
            en_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            init_q  <= init_d;
            en_q    <= en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            drop_q  <= drop_d;
        end
    end

    assign oGnt            = gnt;
    assign oMenuEnable     = en_q[0];
    assign oReactionEnable = en_q[1];
    assign oChimpEnable    = en_q[2];
    assign oX              = x_q;
    assign oY              = y_q;
    assign oColour         = col_q;
    assign oPlot           = plot_q;
    assign oClearing       = (state_q == ST_CLEAR);
    assign oDropped        = drop_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed and randomized checks of the VGA write arbiter against a
// pixel-level reference model of the clear sweep and write path.
module tb_vga_write_arbiter;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  iGameMode = 2'd0;
    logic [2:0]  iReq = 3'd0;
    logic [23:0] iX = '0;
    logic [20:0] iY = '0;
    logic [8:0]  iColour = '0;
    logic [2:0]  oGnt;
    logic        oMenuEnable, oReactionEnable, oChimpEnable;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [2:0]  oColour;
    logic        oPlot, oClearing, oDropped;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the plot port's visible state.
    int ex = 0;
    int ey = 0;
    int ec = 0;
    int edrop = 0;

    always #5 clk = ~clk;

    vga_write_arbiter dut (
        .clk             (clk),
        .resetn          (resetn),
        .iGameMode       (iGameMode),
        .iReq            (iReq),
        .iX              (iX),
        .iY              (iY),
        .iColour         (iColour),
        .oGnt            (oGnt),
        .oMenuEnable     (oMenuEnable),
        .oReactionEnable (oReactionEnable),
        .oChimpEnable    (oChimpEnable),
        .oX              (oX),
        .oY              (oY),
        .oColour         (oColour),
        .oPlot           (oPlot),
        .oClearing       (oClearing),
        .oDropped        (oDropped)
    );

    function automatic logic [2:0] exp_en(input int m);
        return (m < 3) ? 3'(1 << m) : 3'b000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int k, input int x, input int y, input int c);
        iX[k*8 +: 8]      = 8'(x);
        iY[k*7 +: 7]      = 7'(y);
        iColour[k*3 +: 3] = 3'(c);
    endtask

    task automatic sweep(input string tag, input int mode);
        int wait_n = 0;
        int bad    = 0;
        @(negedge clk);
        while (!oPlot && wait_n < 8) begin
            wait_n++;
            @(negedge clk);
        end
        chk({tag, " start"}, 32'(oPlot), 1);
        for (int i = 0; i < NPIX; i++) begin
            if (i > 0) @(negedge clk);
            if (oPlot !== 1'b1 || oX !== 8'(i % W) || oY !== 7'(i / W) ||
                oColour !== 3'd0 || oClearing !== 1'b1 || oGnt !== 3'd0 ||
                {oChimpEnable, oReactionEnable, oMenuEnable} !== 3'd0)
                bad++;
        end
        chk({tag, " pixels"}, 32'(bad), 0);
        @(negedge clk);
        chk({tag, " en"}, {oChimpEnable, oReactionEnable, oMenuEnable}, exp_en(mode));
        chk({tag, " clearing"}, 32'(oClearing), 0);
        chk({tag, " plot"}, 32'(oPlot), 0);
        chk({tag, " drop"}, 32'(oDropped), 0);
        ex = W - 1;
        ey = H - 1;
        ec = 0;
        edrop = 0;
    endtask

    // One write cycle: inputs already driven at a falling edge.
    task automatic write(input string tag, input int mode);
        logic [2:0] g;
        int sx, sy, sc, eplot;
        g = (mode < 3) ? (iReq & exp_en(mode)) : 3'b000;
        eplot = 0;
        #1 chk({tag, " gnt"}, oGnt, g);
        if (g != 3'b000) begin
            sx = int'(iX[mode*8 +: 8]);
            sy = int'(iY[mode*7 +: 7]);
            sc = int'(iColour[mode*3 +: 3]);
            if (sx < W && sy < H) begin
                ex = sx;
                ey = sy;
                ec = sc;
                eplot = 1;
            end else begin
                edrop = 1;
            end
        end
        @(negedge clk);
        chk({tag, " plot"}, 32'(oPlot), eplot);
        chk({tag, " x"}, oX, ex);
        chk({tag, " y"}, oY, ey);
        chk({tag, " col"}, oColour, ec);
        chk({tag, " drop"}, 32'(oDropped), edrop);
        chk({tag, " en"}, {oChimpEnable, oReactionEnable, oMenuEnable}, exp_en(mode));
    endtask

    task automatic random_run(input string tag, input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            iReq = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++)
                set_pix(k, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
            write(tag, mode);
        end
    endtask

    task automatic mode_switch(input string tag, input int to);
        iGameMode = 2'(to);
        #1 chk({tag, " gnt"}, oGnt, 0);
        @(negedge clk);
        chk({tag, " en"}, {oChimpEnable, oReactionEnable, oMenuEnable}, 0);
        chk({tag, " clearing"}, 32'(oClearing), 1);
        chk({tag, " plot"}, 32'(oPlot), 0);
        chk({tag, " drop"}, 32'(oDropped), 0);
        edrop = 0;
    endtask

    initial begin
        int cnt;
        int guard;

        iReq = 3'b111;
        repeat (3) @(negedge clk);
        chk("rst clearing", 32'(oClearing), 1);
        chk("rst plot", 32'(oPlot), 0);
        chk("rst en", {oChimpEnable, oReactionEnable, oMenuEnable}, 0);
        chk("rst drop", 32'(oDropped), 0);
        chk("rst gnt", oGnt, 0);
        chk("rst xy", {oX, oY, oColour}, 0);
        iReq = 3'b000;

        resetn = 1'b1;
        sweep("sweep0", 0);
        random_run("menu", 0, 24);

        // Start a chimp clear, then switch to reaction 5000 plots in.
        iReq = 3'b001;
        mode_switch("chg02", 2);
        iReq = 3'b000;
        cnt = 0;
        guard = 0;
        while (cnt < 5000 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (oPlot) cnt++;
        end
        chk("pre5000 count", 32'(cnt), 5000);
        chk("pre5000 x", oX, 4999 % W);
        chk("pre5000 y", oY, 4999 / W);
        mode_switch("chg21", 1);
        sweep("sweep1", 1);

        iReq = 3'b111;
        set_pix(0, 1, 2, 3);
        set_pix(1, 10, 20, 5);
        set_pix(2, 30, 40, 6);
        write("react dir", 1);
        random_run("react", 1, 24);

        iReq = 3'b010;
        set_pix(1, 50, 60, 7);
        mode_switch("chg12", 2);
        iReq = 3'b000;
        sweep("sweep2", 2);

        iReq = 3'b100;
        set_pix(2, 160, 5, 4);
        write("oob x", 2);
        set_pix(2, 5, 120, 4);
        write("oob y", 2);
        set_pix(2, 7, 8, 2);
        write("after oob", 2);
        random_run("chimp", 2, 24);

        iReq = 3'b000;
        mode_switch("chg23", 3);
        sweep("sweep3", 3);
        random_run("none", 3, 16);

        // Asynchronous reset in the middle of a clear sweep.
        iGameMode = 2'd0;
        repeat (40) @(negedge clk);
        chk("mid plot", 32'(oPlot), 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk("async plot", 32'(oPlot), 0);
        chk("async clearing", 32'(oClearing), 1);
        chk("async xy", {oX, oY}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rerun plot", 32'(oPlot), 1);
        chk("rerun xy", {oX, oY}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
